ain_top: RTL and testbench

- Two-input artificial neuron.
- Computes the weighted sum x1*w1 + x2*w2 of signed inputs, applies ReLU and saturates to the output width.
- Registers the result with one clock of latency.
- Leaf compute block, instantiated by neural-network datapaths that need a single rectified neuron output.

---
 rtl/ain_top.sv | 56 +++++
 tb/tb_ain_top.sv | 134 +++++++++++++
 2 files changed

// File: rtl/ain_top.sv
// Two-input rectified neuron: ReLU(x1*w1 + x2*w2), saturated to OUT_W signed bits, registered.
// The output register clears asynchronously; the result appears one clock after the inputs.
module ain_top #(
   parameter int unsigned IN_W  = 4,
   parameter int unsigned OUT_W = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic signed [IN_W-1:0]  x1,
   input  logic signed [IN_W-1:0]  x2,
   input  logic signed [IN_W-1:0]  w1,
   input  logic signed [IN_W-1:0]  w2,
   output logic signed [OUT_W-1:0] output_val
);

   localparam int unsigned PROD_W = 2 * IN_W;
   localparam int unsigned SUM_W  = 2 * IN_W + 1;
   // Compare width covers both the sum and the saturation bound, plus a sign bit.
   localparam int unsigned CMP_W  = (SUM_W > OUT_W) ? SUM_W + 1 : OUT_W + 1;
   localparam logic signed [CMP_W-1:0] SAT_MAX =
      {{(CMP_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};

   logic signed [PROD_W-1:0] w_prod1;
   logic signed [PROD_W-1:0] w_prod2;
   logic signed [SUM_W-1:0]  w_sum;
   logic signed [CMP_W-1:0]  w_sum_ext;
   logic        [OUT_W-1:0]  w_act;
   logic        [OUT_W-1:0]  r_out;

   assign w_prod1   = PROD_W'(x1) * PROD_W'(w1);
   assign w_prod2   = PROD_W'(x2) * PROD_W'(w2);
   assign w_sum     = SUM_W'(w_prod1) + SUM_W'(w_prod2);
   assign w_sum_ext = CMP_W'(w_sum);

   always_comb begin
      w_act = '0;
      if (w_sum_ext[CMP_W-1] || (w_sum_ext == '0)) begin
         w_act = '0;
      end else if (w_sum_ext > SAT_MAX) begin
         w_act = SAT_MAX[OUT_W-1:0];
      end else begin
         w_act = w_sum_ext[OUT_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out <= '0;
      end else begin
         r_out <= w_act;
      end
   end

   assign output_val = r_out;

endmodule

// File: tb/tb_ain_top.sv
// Directed bench for ain_top: reset behaviour, ReLU/saturation cases, latency and mid-stream reset.
module tb_ain_top;

   localparam int unsigned IN_W  = 4;
   localparam int unsigned OUT_W = 5;

   typedef struct {
      int x1;
      int w1;
      int x2;
      int w2;
      int exp;
   } vec_t;

   logic                    clk;
   logic                    rst;
   logic signed [IN_W-1:0]  x1;
   logic signed [IN_W-1:0]  x2;
   logic signed [IN_W-1:0]  w1;
   logic signed [IN_W-1:0]  w2;
   logic signed [OUT_W-1:0] output_val;

   int n_cmp;
   int n_err;

   vec_t vecs [10] = '{
      '{ 2,  1,  3,  2,  8},   // positive sum
      '{ 1,  1,  3, -1,  0},   // sum -2
      '{ 2,  1,  2, -1,  0},   // sum 0
      '{-8, -8, -8, -8, 15},   // sum 128, saturate
      '{ 3,  5,  0,  0, 15},   // sum 15, exactly at bound
      '{ 4,  4,  0,  0, 15},   // sum 16, just over bound
      '{ 1,  1,  0,  0,  1},
      '{-3,  2,  2,  4,  2},   // -6 + 8
      '{ 7, -8,  7,  7,  0},   // -56 + 49
      '{ 7,  2, -1,  0, 14}
   };

   ain_top #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .x1         (x1),
      .x2         (x2),
      .w1         (w1),
      .w2         (w2),
      .output_val (output_val)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic drive(input vec_t v);
      x1 = 4'(v.x1);
      w1 = 4'(v.w1);
      x2 = 4'(v.x2);
      w2 = 4'(v.w2);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b0;
      drive(vecs[0]);

      // Reset held with nonzero inputs and clock running.
      #1;
      check("reset_async", int'(output_val), 0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check("reset_hold", int'(output_val), 0);
      end

      // Release, then each directed vector one edge at a time.
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("release_no_edge", int'(output_val), 0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), int'(output_val), vecs[i].exp);
      end

      // Back-to-back: new inputs every cycle; old result must hold until the next edge.
      for (int i = 0; i < 10; i++) begin
         int prev;
         prev = vecs[(i + 9) % 10].exp;
         @(negedge clk);
         drive(vecs[i]);
         #1;
         check($sformatf("b2b_hold%0d", i), int'(output_val), prev);
         @(posedge clk);
         #1;
         check($sformatf("b2b_load%0d", i), int'(output_val), vecs[i].exp);
      end

      // Mid-stream reset: output is 14 from the last vector, clears without an edge.
      @(posedge clk);
      #3;
      rst = 1'b0;
      #1;
      check("mid_rst_async", int'(output_val), 0);
      drive(vecs[3]);
      @(posedge clk);
      #1;
      check("mid_rst_edge", int'(output_val), 0);
      @(negedge clk);
      drive(vecs[0]);
      rst = 1'b1;
      #1;
      check("mid_rst_release", int'(output_val), 0);
      @(posedge clk);
      #1;
      check("mid_rst_first", int'(output_val), 8);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
